// File: rtl/out_drain.sv
// out_drain: drains results from port B of the output memory after a compute
// run, packs even/odd result pairs into one word and streams them out over
// valid/ready. A small word FIFO plus a read-credit rule absorbs arbitrary
// backpressure without ever losing a memory read.
//
// Optional feature macro: OUT_DRAIN_ROW_LAST_EN
//   defined   -> m_tlast on every ROW_WORDS-th word (one packet per matrix row)
//   undefined -> m_tlast only on the final word of the run
module out_drain #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 12,
    parameter int NUM_RESULTS = 4096,
    parameter int ROW_WORDS   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_dout,
    output logic [2*DATA_WIDTH-1:0] m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast
);

    localparam int WORD_WIDTH = 2 * DATA_WIDTH;
    localparam int FIFO_DEPTH = 4;
    localparam logic [ADDR_WIDTH:0]   LAST_RD   = (ADDR_WIDTH+1)'(NUM_RESULTS - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(NUM_RESULTS / 2 - 1);

    // Elaboration-time sanity check of the configuration.
    if ((NUM_RESULTS % 2) != 0 || NUM_RESULTS < 2 ||
        NUM_RESULTS > (1 << ADDR_WIDTH) || ROW_WORDS < 1) begin : g_bad_cfg
        $error("out_drain: illegal NUM_RESULTS/ADDR_WIDTH/ROW_WORDS combination");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_FLUSH,
        S_FINISH
    } state_t;

    state_t                  state_q, state_d;
    // Read counter is one bit wider than the address so a run of exactly
    // 2^ADDR_WIDTH results still terminates; the address itself wraps freely.
    logic [ADDR_WIDTH:0]     rd_cnt_q, rd_cnt_d;
    logic                    rd_vld_q, rd_vld_d;      // read data arrives this cycle
    logic                    rd_odd_q, rd_odd_d;      // that data is from an odd address
    logic [DATA_WIDTH-1:0]   lo_q, lo_d;              // low half of the word in assembly
    // Words started (first read issued) but not yet popped from the FIFO:
    // FIFO occupancy plus words in assembly, including reads in flight.
    logic [1:0]              outstanding_q, outstanding_d;
    logic [ADDR_WIDTH-1:0]   word_idx_q, word_idx_d;  // index of next word to push
    logic [1:0]              wr_ptr_q, wr_ptr_d;
    logic [1:0]              rd_ptr_q, rd_ptr_d;
    logic [2:0]              count_q, count_d;

    logic [WORD_WIDTH-1:0]   fifo_data_q [FIFO_DEPTH];
    logic                    fifo_last_q [FIFO_DEPTH];

    logic                    issue;
    logic                    credit_ok;
    logic                    push;
    logic                    pop;
    logic                    push_last;
    logic [WORD_WIDTH-1:0]   push_data;

`ifdef OUT_DRAIN_ROW_LAST_EN
    logic [ADDR_WIDTH-1:0]   row_cnt_q, row_cnt_d;    // word position inside the row
    localparam logic [ADDR_WIDTH-1:0] ROW_LAST = ADDR_WIDTH'(ROW_WORDS - 1);
`endif

    // An even-address read opens a new word, so it needs a free credit; an
    // odd-address read completes a word that is already counted.
    assign credit_ok = rd_cnt_q[0] || (outstanding_q <= 2'd1);

    assign push      = rd_vld_q && rd_odd_q;
    assign push_data = {mem_dout, lo_q};
    assign m_tvalid  = (count_q != 3'd0);
    assign pop       = m_tvalid && m_tready;

    assign m_tdata   = m_tvalid ? fifo_data_q[rd_ptr_q] : '0;
    assign m_tlast   = m_tvalid ? fifo_last_q[rd_ptr_q] : 1'b0;

    assign mem_en    = issue;
    assign mem_addr  = rd_cnt_q[ADDR_WIDTH-1:0];
    assign busy      = (state_q == S_FETCH) || (state_q == S_FLUSH);
    assign done      = (state_q == S_FINISH);

`ifdef OUT_DRAIN_ROW_LAST_EN
    assign push_last = (row_cnt_q == ROW_LAST);
`else
    assign push_last = (word_idx_q == LAST_WORD);
`endif

    // Run control: state transitions and read issue under the credit rule.
    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        issue    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_FETCH;
                    rd_cnt_d = '0;
                end
            end
            S_FETCH: begin
                if (credit_ok) begin
                    issue    = 1'b1;
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    if (rd_cnt_q == LAST_RD) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (outstanding_q == 2'd0 && !rd_vld_q) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath bookkeeping: read pipeline, pair packing, credits, FIFO pointers.
    always_comb begin
        rd_vld_d      = issue;
        rd_odd_d      = rd_cnt_q[0];
        lo_d          = (rd_vld_q && !rd_odd_q) ? mem_dout : lo_q;
        outstanding_d = 2'(3'(outstanding_q) + 3'(issue && !rd_cnt_q[0]) - 3'(pop));
        wr_ptr_d      = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d      = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
        count_d       = count_q + 3'(push) - 3'(pop);
        word_idx_d    = word_idx_q;
        if (state_q == S_IDLE && start) begin
            word_idx_d = '0;
        end else if (push) begin
            word_idx_d = word_idx_q + 1'b1;
        end
    end

`ifdef OUT_DRAIN_ROW_LAST_EN
    // Row position counter for per-row packet boundaries.
    always_comb begin
        row_cnt_d = row_cnt_q;
        if (state_q == S_IDLE && start) begin
            row_cnt_d = '0;
        end else if (push) begin
            row_cnt_d = (row_cnt_q == ROW_LAST) ? '0 : row_cnt_q + 1'b1;
        end
    end

    // Row counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt_q <= '0;
        end else begin
            row_cnt_q <= row_cnt_d;
        end
    end
`endif

    // Control and datapath registers; reset discards any read still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rd_cnt_q      <= '0;
            rd_vld_q      <= 1'b0;
            rd_odd_q      <= 1'b0;
            lo_q          <= '0;
            outstanding_q <= '0;
            word_idx_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            rd_cnt_q      <= rd_cnt_d;
            rd_vld_q      <= rd_vld_d;
            rd_odd_q      <= rd_odd_d;
            lo_q          <= lo_d;
            outstanding_q <= outstanding_d;
            word_idx_q    <= word_idx_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // FIFO storage; contents are gated by count_q so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= push_data;
            fifo_last_q[wr_ptr_q] <= push_last;
        end
    end

endmodule
